// File: rtl/moore_history_display_pkg.sv
// Shared definitions for the Moore history display: state codes, active-low
// seven-segment glyphs and the transition/glyph lookup functions.
package moore_history_display_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic state_t next_state(input state_t cur, input logic in_bit);
    case (cur)
      S0:      return in_bit ? S3 : S1;
      S1:      return in_bit ? S5 : S2;
      S2:      return in_bit ? S0 : S3;
      S3:      return in_bit ? S1 : S4;
      S4:      return in_bit ? S5 : S2;
      S5:      return in_bit ? S4 : S0;
      default: return S0;
    endcase
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [2:0] code);
    case (code)
      3'd0:    return SEG_0;
      3'd1:    return SEG_1;
      3'd2:    return SEG_2;
      3'd3:    return SEG_3;
      3'd4:    return SEG_4;
      3'd5:    return SEG_5;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/moore_history_display_if.sv
// Board-facing signal bundle of the Moore history display: FSM input, step
// controls, and the state/advance/segment/anode outputs.
interface moore_history_display_if
  import moore_history_display_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic              in;
  logic              step_mode;
  logic              step_btn;
  state_t            state;
  logic              advance;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (
    output in, step_mode, step_btn,
    input  state, advance, seg, an
  );

  modport slave (
    input  in, step_mode, step_btn,
    output state, advance, seg, an
  );
endinterface

// File: rtl/moore_history_display_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first tick DIV
// cycles after reset release.
module pulse_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/moore_history_display.sv
// Six-state Moore stepper with a DIGITS-deep state history shown on a
// multiplexed seven-segment display; digit 0 always shows the live state.
module moore_history_display
  import moore_history_display_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int DIGITS   = 4,
  parameter bit SEG_POL  = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  moore_history_display_if.slave bus
);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DEPTH = (DIGITS > 1) ? DIGITS - 1 : 1;

  function automatic logic [6:0] apply_pol(input logic [6:0] pat_low);
    return SEG_POL ? ~pat_low : pat_low;
  endfunction

  logic              in_s1, in_s2;
  logic              btn_s1, btn_s2, btn_prev;
  logic              btn_rise;
  logic              tick_adv, tick_scan;
  logic              adv_req;
  state_t            state_q;
  logic              adv_q;
  logic [2:0]        old_code [DEPTH];
  logic [DEPTH-1:0]  old_vld;
  logic [IW-1:0]     scan_idx;
  logic [2:0]        sel_code;
  logic              sel_vld;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;

  pulse_tick_gen #(.DIV(TICK_DIV)) u_adv_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick_adv)
  );

  pulse_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick_scan)
  );

  // Input synchronisers and button edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_s1    <= 1'b0;
      in_s2    <= 1'b0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      in_s1    <= bus.in;
      in_s2    <= in_s1;
      btn_s1   <= bus.step_btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign btn_rise = btn_s2 & ~btn_prev;
  assign adv_req  = bus.step_mode ? btn_rise : tick_adv;

  // FSM update; advance is high for exactly the cycle the new state appears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
      adv_q   <= 1'b0;
    end else begin
      adv_q <= adv_req;
      if (adv_req) begin
        state_q <= next_state(state_q, in_s2);
      end
    end
  end

  // History: old_code[k] holds the state k+1 advances ago
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      old_vld <= '0;
    end else if (adv_req) begin
      old_vld <= {old_vld[DEPTH-1:0], 1'b1} >> 0;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_req) begin
      old_code[0] <= state_q;
      for (int k = 1; k < DEPTH; k++) begin
        old_code[k] <= old_code[k-1];
      end
    end
  end

  always_comb begin
    sel_code = state_q;
    sel_vld  = 1'b1;
    for (int k = 1; k < DIGITS; k++) begin
      if (scan_idx == IW'(k)) begin
        sel_code = old_code[k-1];
        sel_vld  = old_vld[k-1];
      end
    end
  end

  // Display scan and registered segment/anode drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx <= '0;
      seg_q    <= apply_pol(SEG_0);
      an_q     <= ~DIGITS'(1);
    end else begin
      if (tick_scan) begin
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end
      seg_q <= apply_pol(sel_vld ? seg_pattern(sel_code) : SEG_BLANK);
      an_q  <= ~(DIGITS'(1) << scan_idx);
    end
  end

  assign bus.state   = state_q;
  assign bus.advance = adv_q;
  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
endmodule

// File: tb/tb_moore_history_display.sv
// Bench for moore_history_display: directed scenario plus randomized stepping,
// every cycle compared against a cycle-count/queue reference of the stepper.
module tb_moore_history_display;
  import moore_history_display_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int DIGITS   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  moore_history_display_if #(.DIGITS(DIGITS)) bus();

  moore_history_display #(
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV),
    .DIGITS  (DIGITS),
    .SEG_POL (1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference tables: transitions (in=0, in=1) and active-low glyphs
  int         nxt [8][2] = '{'{1,3}, '{2,5}, '{3,0}, '{4,1}, '{2,5}, '{0,4}, '{0,0}, '{0,0}};
  logic [6:0] segtab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h3F, 7'h3F};

  int n_pass = 0;
  int n_chk  = 0;
  int cyc;
  int m_hist [DIGITS];
  bit in_at  [8192];
  bit btn_at [8192];
  int dut_adv = 0;
  int first_adv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [6:0] seg_of(input int code);
    if (code < 0) return 7'h7F;
    return segtab[code];
  endfunction

  function automatic bit in_v(input int k);
    return (k >= 1) ? in_at[k] : 1'b0;
  endfunction

  function automatic bit btn_v(input int k);
    return (k >= 1) ? btn_at[k] : 1'b0;
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_hist[0] = 0;
    for (int k = 1; k < DIGITS; k++) m_hist[k] = -1;
    first_adv = -1;
  endtask

  // One clock: predict, let the edge happen, compare on the falling edge
  task automatic clk_step();
    int di;
    logic [6:0] es;
    logic [DIGITS-1:0] ea;
    bit adv;
    bit mode;
    int nx;
    di = (cyc / SCAN_DIV) % DIGITS;
    es = seg_of(m_hist[di]);
    ea = ~(DIGITS'(1) << di);
    @(posedge clk);
    cyc++;
    mode = bus.step_mode;
    in_at[cyc]  = bus.in;
    btn_at[cyc] = bus.step_btn;
    if (mode) adv = btn_v(cyc - 2) && !btn_v(cyc - 3);
    else      adv = (cyc % TICK_DIV) == 0;
    if (adv) begin
      nx = nxt[m_hist[0]][in_v(cyc - 2)];
      for (int k = DIGITS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = nx;
    end
    @(negedge clk);
    chk("state",   bus.state,   m_hist[0]);
    chk("advance", bus.advance, adv);
    chk("seg",     bus.seg,     es);
    chk("an",      bus.an,      ea);
    if (bus.advance) begin
      dut_adv++;
      if (first_adv < 0) first_adv = cyc;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) clk_step();
  endtask

  task automatic press(input int hold, input int gap);
    bus.step_btn = 1'b1;
    repeat (hold) clk_step();
    bus.step_btn = 1'b0;
    bus.in = 1'($urandom_range(0, 1));
    repeat (gap) clk_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int tgt;
    int k;
    bus.in = 1'b0;
    bus.step_mode = 1'b0;
    bus.step_btn = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_adv",   bus.advance, 0);
    chk("rst_seg",   bus.seg, 7'h40);
    chk("rst_an",    bus.an, 4'b1110);
    reset = 1'b1;

    // Auto-advance with in=0: S1, S2, S3 at cycles 4, 8, 12
    run_to(12);
    chk("t1_first_adv", first_adv, 4);
    chk("t2_state", bus.state, 3);
    run_to(15);
    chk("t2_an_d3",  bus.an, 4'b0111);
    chk("t2_seg_d3", bus.seg, 7'h40);

    // S3->S4->S2, then in=1 leads back to S0 and on through 3,1,5,4,5
    run_to(20);
    chk("t3_s2", bus.state, 2);
    bus.in = 1'b1;
    run_to(44);
    chk("t3_state", bus.state, 5);
    bus.step_mode = 1'b1;
    bus.in = 1'b0;
    run_to(46);
    chk("t3_an_d2",  bus.an, 4'b1011);
    chk("t3_seg_d2", bus.seg, 7'h12);
    run_to(49);
    chk("t3_an_d0",  bus.an, 4'b1110);
    chk("t3_seg_d0", bus.seg, 7'h12);

    // Illegal code 6 shows a dash and recovers to S0 on the next advance
    run_to(50);
    force dut.state_q = state_t'(3'd6);
    m_hist[0] = 6;
    run_to(57);
    chk("t6_state6", bus.state, 6);
    chk("t6_an_d0",  bus.an, 4'b1110);
    chk("t6_seg",    bus.seg, 7'h3F);
    run_to(58);
    bus.step_btn = 1'b1;
    run_to(60);
    release dut.state_q;
    run_to(61);
    chk("t6_adv",   bus.advance, 1);
    chk("t6_state", bus.state, 0);
    bus.step_btn = 1'b0;
    run_to(66);

    // Step mode: long hold plus two short presses give exactly three advances
    a0 = dut_adv;
    press(50, 5);
    press(2, 5);
    press(3, 6);
    chk("t4_adv_count", dut_adv - a0, 3);

    // Randomized auto stepping, in changed right after each advance
    bus.step_mode = 1'b0;
    for (int n = 0; n < 24; n++) begin
      tgt = dut_adv + 1;
      k = 0;
      while (dut_adv < tgt && k < 8) begin
        clk_step();
        k++;
      end
      if (dut_adv < tgt) chk("rnd_auto_timeout", dut_adv, tgt);
      bus.in = 1'($urandom_range(0, 1));
    end

    // Randomized button stepping
    bus.step_mode = 1'b1;
    a0 = dut_adv;
    for (int n = 0; n < 20; n++) begin
      press($urandom_range(1, 6), $urandom_range(4, 8));
    end
    chk("rnd_step_count", dut_adv - a0, 20);

    // Asynchronous reset in the middle of a scan slot with a non-zero state
    bus.step_mode = 1'b0;
    k = 0;
    while ((m_hist[0] == 0 || (((cyc - 1) / SCAN_DIV) % DIGITS) == 0) && k < 64) begin
      clk_step();
      k++;
    end
    bus.in = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5_state", bus.state, 0);
    chk("t5_adv",   bus.advance, 0);
    chk("t5_seg",   bus.seg, 7'h40);
    chk("t5_an",    bus.an, 4'b1110);
    #4 reset = 1'b1;
    model_reset();
    run_to(20);
    chk("t5_first_adv", first_adv, 4);
    chk("t5_state_after", bus.state, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
